// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone round-robin arbiter; grant is held for the whole CYC.
// Optional bus-timeout watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int NUM_M       = 2,
    parameter int ADR_W       = 30,
    parameter int DAT_W       = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_M-1:0]           m_CYC,
    input  logic [NUM_M-1:0]           m_STB,
    input  logic [NUM_M-1:0]           m_WE,
    input  logic [NUM_M*ADR_W-1:0]     m_ADR,
    input  logic [NUM_M*DAT_W-1:0]     m_DAT_MOSI,
    input  logic [NUM_M*DAT_W/8-1:0]   m_SEL,
    input  logic [NUM_M*3-1:0]         m_CTI,
    input  logic [NUM_M*2-1:0]         m_BTE,
    output logic [NUM_M-1:0]           m_ACK,
    output logic [NUM_M-1:0]           m_ERR,
    output logic [NUM_M*DAT_W-1:0]     m_DAT_MISO,
    output logic                       s_CYC,
    output logic                       s_STB,
    output logic                       s_WE,
    output logic [ADR_W-1:0]           s_ADR,
    output logic [DAT_W-1:0]           s_DAT_MOSI,
    output logic [DAT_W/8-1:0]         s_SEL,
    output logic [2:0]                 s_CTI,
    output logic [1:0]                 s_BTE,
    input  logic                       s_ACK,
    input  logic                       s_ERR,
    input  logic [DAT_W-1:0]           s_DAT_MISO
);
    localparam int SEL_W = DAT_W / 8;
    localparam int GW    = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [NUM_M-1:0] req;
    logic            busy, g_cyc, g_stb, timeout_hit;

    // First requester at or after (last+1) mod NUM_M.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_M-1:0] r, input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = (int'(last) + k) % NUM_M;
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
        return pick;
    endfunction

    assign req   = m_CYC & m_STB;
    assign busy  = (state_q == ST_BUSY);
    assign g_cyc = m_CYC[grant_q];
    assign g_stb = m_STB[grant_q];

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timer_q, timer_d;

    assign timeout_hit = busy && g_cyc && g_stb && !s_ACK && !s_ERR
                         && (timer_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        timer_d = '0;
        if (busy && g_cyc && g_stb && !s_ACK && !s_ERR && !timeout_hit)
            timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = rr_pick(req, last_q);
                    state_d = ST_BUSY;
                end
            end
            default: begin
                if (!g_cyc || timeout_hit) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_M - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        s_CYC      = 1'b0;
        s_STB      = 1'b0;
        s_WE       = 1'b0;
        s_ADR      = '0;
        s_DAT_MOSI = '0;
        s_SEL      = '0;
        s_CTI      = '0;
        s_BTE      = '0;
        m_ACK      = '0;
        m_ERR      = '0;
        m_DAT_MISO = '0;
        if (busy && g_cyc && !timeout_hit) begin
            s_CYC      = 1'b1;
            s_STB      = g_stb;
            s_WE       = m_WE[grant_q];
            s_ADR      = m_ADR[grant_q*ADR_W +: ADR_W];
            s_DAT_MOSI = m_DAT_MOSI[grant_q*DAT_W +: DAT_W];
            s_SEL      = m_SEL[grant_q*SEL_W +: SEL_W];
            s_CTI      = m_CTI[grant_q*3 +: 3];
            s_BTE      = m_BTE[grant_q*2 +: 2];
        end
        if (busy) begin
            m_DAT_MISO[grant_q*DAT_W +: DAT_W] = s_DAT_MISO;
            // Responses count only against the master's own strobe, so a final
            // ACK arriving as CYC drops still reaches it.
            if (g_stb) begin
                m_ACK[grant_q] = s_ACK;
                m_ERR[grant_q] = s_ERR;
            end
            if (timeout_hit) m_ERR[grant_q] = 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (4 masters); timeout section follows WB_ARB_TIMEOUT_EN.
module tb_wb_rr_arbiter;
    localparam int NM = 4;
    localparam int AW = 30;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NM-1:0]     m_CYC, m_STB, m_WE;
    logic [NM*AW-1:0]  m_ADR;
    logic [NM*DW-1:0]  m_DAT_MOSI;
    logic [NM*DW/8-1:0] m_SEL;
    logic [NM*3-1:0]   m_CTI;
    logic [NM*2-1:0]   m_BTE;
    logic [NM-1:0]     m_ACK, m_ERR;
    logic [NM*DW-1:0]  m_DAT_MISO;
    logic              s_CYC, s_STB, s_WE;
    logic [AW-1:0]     s_ADR;
    logic [DW-1:0]     s_DAT_MOSI;
    logic [DW/8-1:0]   s_SEL;
    logic [2:0]        s_CTI;
    logic [1:0]        s_BTE;
    logic              s_ACK, s_ERR;
    logic [DW-1:0]     s_DAT_MISO;

    int total = 0;
    int bad   = 0;

    wb_rr_arbiter #(.NUM_M(NM), .ADR_W(AW), .DAT_W(DW), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset),
        .m_CYC(m_CYC), .m_STB(m_STB), .m_WE(m_WE), .m_ADR(m_ADR),
        .m_DAT_MOSI(m_DAT_MOSI), .m_SEL(m_SEL), .m_CTI(m_CTI), .m_BTE(m_BTE),
        .m_ACK(m_ACK), .m_ERR(m_ERR), .m_DAT_MISO(m_DAT_MISO),
        .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE), .s_ADR(s_ADR),
        .s_DAT_MOSI(s_DAT_MOSI), .s_SEL(s_SEL), .s_CTI(s_CTI), .s_BTE(s_BTE),
        .s_ACK(s_ACK), .s_ERR(s_ERR), .s_DAT_MISO(s_DAT_MISO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input bit c, input bit s, input bit we,
                         input logic [AW-1:0] adr, input logic [2:0] cti);
        m_CYC[i] = c;
        m_STB[i] = s;
        m_WE[i]  = we;
        m_ADR[i*AW +: AW] = adr;
        m_DAT_MOSI[i*DW +: DW] = {2'b00, adr} ^ 32'h5A5A_0000;
        m_SEL[i*4 +: 4] = 4'hF;
        m_CTI[i*3 +: 3] = cti;
        m_BTE[i*2 +: 2] = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        m_CYC = '0; m_STB = '0; m_WE = '0; m_ADR = '0; m_DAT_MOSI = '0;
        m_SEL = '0; m_CTI = '0; m_BTE = '0;
        s_ACK = 1'b0; s_ERR = 1'b0; s_DAT_MISO = 32'hA5A5_A5A5;

        // Reset held 3 cycles, outputs all zero
        cyc(); cyc(); cyc();
        chk("rst_s_cyc", 64'(s_CYC), 64'd0);
        chk("rst_s_stb", 64'(s_STB), 64'd0);
        chk("rst_s_adr", 64'(s_ADR), 64'd0);
        chk("rst_m_ack", 64'(m_ACK), 64'd0);
        chk("rst_m_err", 64'(m_ERR), 64'd0);
        chk("rst_m_dat_lo", m_DAT_MISO[63:0], 64'd0);
        reset = 1'b0;
        cyc(); cyc();
        chk("idle_no_req", 64'(s_CYC), 64'd0);

        // Single read from m1, one-cycle arbitration latency
        set_m(1, 1, 1, 0, 30'h100, 3'b000);
        #1 chk("m1_latency", 64'(s_CYC), 64'd0);
        cyc();
        chk("m1_s_cyc", 64'(s_CYC), 64'd1);
        chk("m1_s_stb", 64'(s_STB), 64'd1);
        chk("m1_s_adr", 64'(s_ADR), 64'h100);
        chk("m1_s_we", 64'(s_WE), 64'd0);
        s_ACK = 1'b1; s_DAT_MISO = 32'hDEAD_BEEF;
        #1;
        chk("m1_ack", 64'(m_ACK), 64'b0010);
        chk("m1_data", 64'(m_DAT_MISO[63:32]), 64'hDEAD_BEEF);
        chk("m0_data_zero", 64'(m_DAT_MISO[31:0]), 64'd0);
        cyc();
        s_ACK = 1'b0;
        set_m(1, 0, 0, 0, 30'h100, 3'b000);
        #1 chk("m1_drop_s_cyc", 64'(s_CYC), 64'd0);
        cyc();

        // m0 and m1 together: m0 first, one idle cycle, then m1
        set_m(0, 1, 1, 1, 30'h200, 3'b000);
        set_m(1, 1, 1, 0, 30'h300, 3'b000);
        cyc();
        chk("pair_first_adr", 64'(s_ADR), 64'h200);
        chk("pair_first_we", 64'(s_WE), 64'd1);
        chk("pair_first_dat", 64'(s_DAT_MOSI), 64'(32'h5A5A_0200));
        s_ACK = 1'b1;
        #1 chk("pair_m0_ack_only", 64'(m_ACK), 64'b0001);
        cyc();
        s_ACK = 1'b0;
        set_m(0, 0, 0, 0, 30'h200, 3'b000);
        #1 chk("pair_m0_drop", 64'(s_CYC), 64'd0);
        cyc();
        chk("pair_idle_gap", 64'(s_CYC), 64'd0);
        cyc();
        chk("pair_second_cyc", 64'(s_CYC), 64'd1);
        chk("pair_second_adr", 64'(s_ADR), 64'h300);
        // ACK arrives in the cycle m1 drops CYC
        s_ACK = 1'b1;
        m_CYC[1] = 1'b0;
        #1;
        chk("ack_with_drop_ack", 64'(m_ACK), 64'b0010);
        chk("ack_with_drop_cyc", 64'(s_CYC), 64'd0);
        cyc();
        s_ACK = 1'b0;
        m_STB[1] = 1'b0;
        #1 chk("after_drop_idle", 64'(s_CYC), 64'd0);

        // m0 incrementing burst with m1 waiting; STB gap must not split it
        set_m(0, 1, 1, 0, 30'h400, 3'b010);
        set_m(1, 1, 1, 0, 30'h500, 3'b000);
        cyc();
        chk("burst_cti", 64'(s_CTI), 64'd2);
        for (int b = 0; b < 4; b++) begin
            set_m(0, 1, 1, 0, 30'h400 + 30'(b), (b == 3) ? 3'b111 : 3'b010);
            s_ACK = 1'b1;
            #1;
            chk("burst_ack", 64'(m_ACK), 64'b0001);
            chk("burst_adr", 64'(s_ADR), 64'h400 + 64'(b));
            cyc();
            if (b == 1) begin
                m_STB[0] = 1'b0;
                #1;
                chk("gap_ack_ignored", 64'(m_ACK), 64'd0);
                chk("gap_s_stb", 64'(s_STB), 64'd0);
                chk("gap_hold_adr", 64'(s_ADR), 64'h401);
                cyc();
            end
        end
        s_ACK = 1'b0;
        set_m(0, 0, 0, 0, 30'h0, 3'b000);
        #1 chk("burst_end_cyc", 64'(s_CYC), 64'd0);
        cyc();
        chk("burst_idle", 64'(s_CYC), 64'd0);
        cyc();
        chk("burst_then_m1", 64'(s_ADR), 64'h500);
        set_m(1, 0, 0, 0, 30'h0, 3'b000);
        cyc();

        // Error forwarding, then reset in the middle of a transfer
        set_m(2, 1, 1, 0, 30'h600, 3'b000);
        cyc();
        chk("m2_granted", 64'(s_ADR), 64'h600);
        s_ERR = 1'b1;
        #1 chk("m2_err_fwd", 64'(m_ERR), 64'b0100);
        s_ERR = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        set_m(2, 0, 0, 0, 30'h0, 3'b000);
        #1 chk("midreset_cyc", 64'(s_CYC), 64'd0);

        // All four masters requesting: order 0,1,2,3,0
        for (int i = 0; i < NM; i++) set_m(i, 1, 1, 0, 30'h10 + 30'(i), 3'b000);
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % NM;
            cyc();
            chk("rr_order", 64'(s_ADR), 64'h10 + 64'(e));
            m_CYC[e] = 1'b0;
            m_STB[e] = 1'b0;
            cyc();
            chk("rr_idle", 64'(s_CYC), 64'd0);
            m_CYC[e] = 1'b1;
            m_STB[e] = 1'b1;
        end
        m_CYC = '0;
        m_STB = '0;
        cyc();

        // Slave that never answers
        set_m(3, 1, 1, 0, 30'h700, 3'b000);
        cyc();
`ifdef WB_ARB_TIMEOUT_EN
        for (int n = 0; n < 15; n++) begin
            chk("to_no_err_yet", 64'(m_ERR), 64'd0);
            chk("to_stb_held", 64'(s_STB), 64'd1);
            cyc();
        end
        chk("to_err_pulse", 64'(m_ERR), 64'b1000);
        chk("to_s_cyc_low", 64'(s_CYC), 64'd0);
        cyc();
        chk("to_err_single", 64'(m_ERR), 64'd0);
        chk("to_idle", 64'(s_CYC), 64'd0);
`else
        for (int n = 0; n < 20; n++) begin
            chk("wait_no_err", 64'(m_ERR), 64'd0);
            chk("wait_cyc_held", 64'(s_CYC), 64'd1);
            cyc();
        end
`endif
        set_m(3, 0, 0, 0, 30'h0, 3'b000);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
